// File: rtl/xor_hash_pkg.sv
// Shared defaults and types for the URAM bank gather path.
// The GATHER_BANK_MASK_EN macro adds a per-bank mask field to gather_req_t.
package xor_hash_pkg;

  localparam int unsigned XH_NUM_XOR    = 16;
  localparam int unsigned XH_DATA_WIDTH = 64;
  localparam int unsigned XH_ADDR_WIDTH = 12;
  localparam int unsigned XH_TAG_WIDTH  = 8;

  typedef struct packed {
    logic [XH_NUM_XOR*XH_ADDR_WIDTH-1:0] addr;
    logic [XH_TAG_WIDTH-1:0]             tag;
`ifdef GATHER_BANK_MASK_EN
    logic [XH_NUM_XOR-1:0]               mask;
`endif
  } gather_req_t;

  // FIFO index width; pointers carry one extra wrap bit on top of this.
  function automatic int unsigned fifo_aw(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gather_fifo.sv
// Show-ahead FIFO for gathered words. No internal full/empty protection: the
// caller guarantees no push when full (credit) and no pop when empty.
module gather_fifo
  import xor_hash_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned AW = fifo_aw(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/uram_bank_gather.sv
// Issues one read across NUM_XOR banks per accepted request, tracks the fixed bank
// latency with a valid/tag delay line and buffers the concatenated word in a FIFO.
// Optional: GATHER_BANK_MASK_EN adds req_mask to enable a subset of banks and zero
// the masked slices at capture.
module uram_bank_gather
  import xor_hash_pkg::*;
#(
  parameter int unsigned NUM_XOR    = XH_NUM_XOR,
  parameter int unsigned DATA_WIDTH = XH_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = XH_ADDR_WIDTH,
  parameter int unsigned TAG_WIDTH  = XH_TAG_WIDTH,
  parameter int unsigned RD_LAT     = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [NUM_XOR*ADDR_WIDTH-1:0]    req_addr,
  input  logic [TAG_WIDTH-1:0]             req_tag,
`ifdef GATHER_BANK_MASK_EN
  input  logic [NUM_XOR-1:0]               req_mask,
`endif
  output logic [NUM_XOR-1:0]               bank_en,
  output logic [NUM_XOR*ADDR_WIDTH-1:0]    bank_addr,
  input  logic [NUM_XOR*DATA_WIDTH-1:0]    bank_rdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_XOR*DATA_WIDTH-1:0]    out_data,
  output logic [TAG_WIDTH-1:0]             out_tag
);

  localparam int unsigned AW    = fifo_aw(FIFO_DEPTH);
  localparam int unsigned WORDW = NUM_XOR * DATA_WIDTH;
  localparam int unsigned FW    = TAG_WIDTH + WORDW;
  localparam logic [AW:0] LP_DEPTH = (AW + 1)'(FIFO_DEPTH);

  logic                 w_accept;
  logic                 w_pop;
  logic [NUM_XOR-1:0]   w_req_mask;
  logic [AW:0]          r_occ;

  logic [RD_LAT:0]      r_dl_vld;
  logic [TAG_WIDTH-1:0] r_dl_tag  [RD_LAT+1];
  logic [NUM_XOR-1:0]   r_dl_mask [RD_LAT+1];

  logic                 w_push;
  logic [WORDW-1:0]     w_cap_data;
  logic [FW-1:0]        w_fifo_rdata;
  logic                 w_empty;
  logic                 w_full;
  logic [WORDW-1:0]     r_last_data;
  logic [TAG_WIDTH-1:0] r_last_tag;

`ifdef GATHER_BANK_MASK_EN
  assign w_req_mask = req_mask;
`else
  assign w_req_mask = '1;
`endif

  // Credit: occupancy covers reads in flight plus buffered words.
  assign req_ready = (r_occ < LP_DEPTH);
  assign w_accept  = req_valid && req_ready;
  assign w_pop     = out_valid && out_ready;

  // Occupancy counter; simultaneous accept and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (w_accept && !w_pop) begin
      r_occ <= r_occ + (AW + 1)'(1);
    end else if (w_pop && !w_accept) begin
      r_occ <= r_occ - (AW + 1)'(1);
    end
  end

  // Bank issue registers; address holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_en   <= '0;
      bank_addr <= '0;
    end else begin
      bank_en <= w_accept ? w_req_mask : '0;
      if (w_accept) bank_addr <= req_addr;
    end
  end

  // Alignment delay line: stage k is visible k+1 cycles after the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dl_vld <= '0;
      for (int k = 0; k <= RD_LAT; k++) begin
        r_dl_tag[k]  <= '0;
        r_dl_mask[k] <= '0;
      end
    end else begin
      r_dl_vld[0]  <= w_accept;
      r_dl_tag[0]  <= req_tag;
      r_dl_mask[0] <= w_req_mask;
      for (int k = 1; k <= RD_LAT; k++) begin
        r_dl_vld[k]  <= r_dl_vld[k-1];
        r_dl_tag[k]  <= r_dl_tag[k-1];
        r_dl_mask[k] <= r_dl_mask[k-1];
      end
    end
  end

  // Capture: masked banks contribute zero so they are neutral in the XOR tree.
  always_comb begin
    w_cap_data = bank_rdata;
    for (int i = 0; i < NUM_XOR; i++) begin
      if (!r_dl_mask[RD_LAT][i]) w_cap_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end

  assign w_push = r_dl_vld[RD_LAT];

  gather_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({r_dl_tag[RD_LAT], w_cap_data}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Last popped word, shown while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_data <= '0;
      r_last_tag  <= '0;
    end else if (w_pop) begin
      r_last_data <= w_fifo_rdata[WORDW-1:0];
      r_last_tag  <= w_fifo_rdata[FW-1:WORDW];
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? r_last_data : w_fifo_rdata[WORDW-1:0];
  assign out_tag   = w_empty ? r_last_tag  : w_fifo_rdata[FW-1:WORDW];

  // Credit accounting must make an overflowing push unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_uram_bank_gather.sv
// Self-checking bench for uram_bank_gather: table of single requests plus
// hand-written multi-cycle sequences, with a scoreboard on the output side.
module tb_uram_bank_gather;

  localparam int unsigned NX = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 12;
  localparam int unsigned TW = 8;
  localparam int unsigned RL = 3;
  localparam int unsigned FD = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [NX*AW-1:0]   req_addr;
  logic [TW-1:0]      req_tag;
  logic [NX-1:0]      req_mask;
  logic [NX-1:0]      bank_en;
  logic [NX*AW-1:0]   bank_addr;
  logic [NX*DW-1:0]   bank_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [NX*DW-1:0]   out_data;
  logic [TW-1:0]      out_tag;

  uram_bank_gather #(
    .NUM_XOR    (NX),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TAG_WIDTH  (TW),
    .RD_LAT     (RL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_tag    (req_tag),
`ifdef GATHER_BANK_MASK_EN
    .req_mask   (req_mask),
`endif
    .bank_en    (bank_en),
    .bank_addr  (bank_addr),
    .bank_rdata (bank_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_pop = 0;
  int pop_cyc[$];

  typedef struct {
    logic [TW-1:0]    tag;
    logic [NX*DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [TW-1:0] tag;
    logic [AW-1:0] base;
    int            exp_lat;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [DW-1:0] bank_word(int i, logic [AW-1:0] a);
    return {8'(i), 4'h0, a, 8'h5A, 4'h0, ~a, 16'(i * 7 + 1)};
  endfunction

  // Bank model: disabled banks return all-ones so masking is observable.
  function automatic logic [NX*DW-1:0] bank_model(logic [NX-1:0] en, logic [NX*AW-1:0] a);
    logic [NX*DW-1:0] r;
    for (int i = 0; i < NX; i++)
      r[i*DW +: DW] = en[i] ? bank_word(i, a[i*AW +: AW]) : '1;
    return r;
  endfunction

  function automatic logic [NX*DW-1:0] exp_data(logic [NX-1:0] m, logic [NX*AW-1:0] a);
    logic [NX*DW-1:0] r;
    for (int i = 0; i < NX; i++)
      r[i*DW +: DW] = m[i] ? bank_word(i, a[i*AW +: AW]) : '0;
    return r;
  endfunction

  // RL-cycle bank pipeline, not affected by DUT reset.
  logic [NX*DW-1:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= bank_model(bank_en, bank_addr);
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign bank_rdata = pipe[RL-1];

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        sb.push_back('{tag: req_tag, data: exp_data(req_mask, req_addr)});
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_pop++;
        pop_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got tag %0h expected no output", out_tag);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_tag", 256'(out_tag), 256'(e.tag));
          n_checks++;
          if (out_data !== e.data) begin
            n_errors++;
            for (int i = 0; i < NX; i++) begin
              if (out_data[i*DW +: DW] !== e.data[i*DW +: DW]) begin
                $display("FAIL sb_data bank %0d: got %h expected %h", i,
                         out_data[i*DW +: DW], e.data[i*DW +: DW]);
                break;
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(logic [AW-1:0] base);
    for (int i = 0; i < NX; i++) req_addr[i*AW +: AW] = base + AW'(i);
  endtask

  task automatic drain(string nm);
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    chk(nm, 256'(sb.size()), 256'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bad, a0, p0;

    vecs[0] = '{tag: 8'h5A, base: 12'h010, exp_lat: RL + 2};
    vecs[1] = '{tag: 8'hA3, base: 12'hFF0, exp_lat: RL + 2};
    vecs[2] = '{tag: 8'h00, base: 12'h000, exp_lat: RL + 2};
    vecs[3] = '{tag: 8'hFF, base: 12'h7FF, exp_lat: RL + 2};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_tag = '0; req_mask = '1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_tag", 256'(out_tag), 256'(0));
    chk("rst_out_data_zero", 256'(out_data == '0), 256'(1));
    chk("rst_bank_en", 256'(bank_en), 256'(0));
    chk("rst_bank_addr", 256'(bank_addr), 256'(0));
    chk("rst_req_ready", 256'(req_ready), 256'(1));

    // Single requests: issue timing, latency and returned tag.
    for (int v = 0; v < 4; v++) begin
      set_addr(vecs[v].base);
      req_tag = vecs[v].tag;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("t1_bank_en", 256'(bank_en), 256'(req_mask));
      chk("t1_bank_addr", 256'(bank_addr), 256'(req_addr));
      lat = 1;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      chk("t1_latency", 256'(lat), 256'(vecs[v].exp_lat));
      chk("t1_out_tag", 256'(out_tag), 256'(vecs[v].tag));
      drain("t1_drain");
    end

    // 20 back-to-back requests at full rate.
    pop_cyc.delete();
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      set_addr(AW'(t * 16 + 3));
      req_tag = TW'(t);
      req_valid = 1'b1;
      if (!req_ready) bad++;
      tick();
    end
    req_valid = 1'b0;
    chk("t2_ready_stall_cycles", 256'(bad), 256'(0));
    drain("t2_drain");
    chk("t2_pop_count", 256'(pop_cyc.size()), 256'(20));
    if (pop_cyc.size() == 20)
      chk("t2_consecutive", 256'(pop_cyc[19] - pop_cyc[0]), 256'(19));

    // Backpressure: credit caps acceptance at FD.
    out_ready = 1'b0;
    a0 = n_acc;
    for (int t = 0; t < 14; t++) begin
      set_addr(AW'(12'h300 + t));
      req_tag = TW'(8'h40 + t);
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    chk("t3_accepted", 256'(n_acc - a0), 256'(FD));
    chk("t3_ready_low", 256'(req_ready), 256'(0));
    repeat (8) tick();
    chk("t3_valid_full", 256'(out_valid), 256'(1));
    chk("t3_ready_still_low", 256'(req_ready), 256'(0));
    out_ready = 1'b1;
    chk("t3_ready_before_pop", 256'(req_ready), 256'(0));
    tick();
    chk("t3_ready_after_pop", 256'(req_ready), 256'(1));
    drain("t3_drain");

    // occ=7 with simultaneous accept and pop.
    out_ready = 1'b0;
    p0 = n_pop;
    for (int t = 0; t < 7; t++) begin
      set_addr(AW'(12'h500 + t * 2));
      req_tag = TW'(8'h80 + t);
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    repeat (8) tick();
    chk("t4_valid", 256'(out_valid), 256'(1));
    chk("t4_ready_occ7", 256'(req_ready), 256'(1));
    set_addr(12'h5A0);
    req_tag = 8'h87;
    req_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    out_ready = 1'b0;
    chk("t4_ready_after_both", 256'(req_ready), 256'(1));
    set_addr(12'h5B0);
    req_tag = 8'h88;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t4_ready_occ8", 256'(req_ready), 256'(0));
    drain("t4_drain");
    chk("t4_pop_total", 256'(n_pop - p0), 256'(9));

    // Reset with reads in flight.
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      set_addr(AW'(12'h700 + t));
      req_tag = TW'(8'hC0 + t);
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    #2;
    chk("t5_out_valid", 256'(out_valid), 256'(0));
    chk("t5_out_data_zero", 256'(out_data == '0), 256'(1));
    chk("t5_out_tag", 256'(out_tag), 256'(0));
    tick();
    rst = 1'b0;
    bad = 0;
    for (int t = 0; t < RL + 3; t++) begin
      if (out_valid) bad++;
      tick();
    end
    chk("t5_no_stale_capture", 256'(bad), 256'(0));
    p0 = n_pop;
    set_addr(12'h0EE);
    req_tag = 8'hEE;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    drain("t5_drain");
    chk("t5_pop_count", 256'(n_pop - p0), 256'(1));

`ifdef GATHER_BANK_MASK_EN
    // Masked banks: only enabled banks read, others captured as zero.
    req_mask = 16'h00FF;
    set_addr(12'h123);
    req_tag = 8'h6D;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t6_bank_en", 256'(bank_en), 256'(16'h00FF));
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("t6_latency", 256'(lat), 256'(RL + 2));
    chk("t6_upper_zero", 256'(out_data[NX*DW-1:NX*DW/2] == '0), 256'(1));
    drain("t6_drain");
    req_mask = '1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
